// File: rtl/isram_loader.sv
// rtl/isram_loader.sv - packs 48-bit chunk stream into 240-bit instruction SRAM writes
module isram_loader #(
    parameter int CHUNK_W = 48,
    parameter int CHUNKS  = 5,
    parameter int ADDR_W  = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHUNK_W-1:0]          in_data,
    input  logic                        in_last,
    output logic                        iMem_WEPin,
    output logic [ADDR_W-1:0]           iMem_WEAddress,
    output logic [CHUNK_W*CHUNKS-1:0]   idataWrite,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [ADDR_W:0]             word_count
);

    localparam int WORD_W = CHUNK_W * CHUNKS;
    localparam int CNT_W  = $clog2(CHUNKS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic                last_seen_q, last_seen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   we_addr_q, we_addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                in_ready_q, in_ready_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WORD_W-1:0]   packed_word;
    logic                hs;
    logic                closing;

    // Next-state, datapath and registered-output decode; outputs follow the next state
    // so that each output flop lines up with the state it describes.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pack_d       = pack_q;
        last_seen_d  = last_seen_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        error_d      = error_q;
        we_addr_d    = we_addr_q;
        wdata_d      = wdata_q;

        // Current buffer with the incoming chunk dropped into its slot; unfilled
        // slots are already zero because the buffer is cleared between words.
        packed_word = pack_q;
        for (int i = 0; i < CHUNKS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                packed_word[i*CHUNK_W +: CHUNK_W] = in_data;
            end
        end

        hs      = in_valid & in_ready_q;
        closing = (cnt_q == CNT_W'(CHUNKS - 1)) | in_last;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    word_count_d = '0;
                    error_d      = 1'b0;
                    pack_d       = '0;
                    cnt_d        = '0;
                    last_seen_d  = 1'b0;
                    state_d      = COLLECT;
                end
            end
            COLLECT: begin
                if (hs) begin
                    pack_d = packed_word;
                    cnt_d  = cnt_q + 1'b1;
                    if (closing) begin
                        last_seen_d = in_last;
                        wdata_d     = packed_word;
                        we_addr_d   = addr_q;
                        state_d     = WRITE;
                    end
                end
            end
            WRITE: begin
                word_count_d = word_count_q + 1'b1;
                pack_d       = '0;
                cnt_d        = '0;
                if (last_seen_q) begin
                    state_d = FINISH;
                end else if (addr_q == {ADDR_W{1'b1}}) begin
                    // Top of the SRAM reached with more program pending: stop, never wrap.
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = COLLECT;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == COLLECT);
        we_d       = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FINISH);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pack_q       <= '0;
            last_seen_q  <= 1'b0;
            addr_q       <= '0;
            word_count_q <= '0;
            error_q      <= 1'b0;
            we_addr_q    <= '0;
            wdata_q      <= '0;
            in_ready_q   <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pack_q       <= pack_d;
            last_seen_q  <= last_seen_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            error_q      <= error_d;
            we_addr_q    <= we_addr_d;
            wdata_q      <= wdata_d;
            in_ready_q   <= in_ready_d;
            we_q         <= we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign iMem_WEPin     = we_q;
    assign iMem_WEAddress = we_addr_q;
    assign idataWrite     = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign word_count     = word_count_q;

endmodule

// File: tb/tb_isram_loader.sv
// tb/tb_isram_loader.sv - randomized self-checking bench for isram_loader
module tb_isram_loader;

    localparam int CW = 48;
    localparam int CH = 5;
    localparam int AW = 8;
    localparam int WW = CW * CH;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_data;
    logic          in_last;
    logic          iMem_WEPin;
    logic [AW-1:0] iMem_WEAddress;
    logic [WW-1:0] idataWrite;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   word_count;

    isram_loader #(.CHUNK_W(CW), .CHUNKS(CH), .ADDR_W(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .iMem_WEPin     (iMem_WEPin),
        .iMem_WEAddress (iMem_WEAddress),
        .idataWrite     (idataWrite),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .word_count     (word_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stimulus program
    logic [CW-1:0] ch[16];
    logic          lst[16];

    // Write monitor: records every WE cycle and flags any WE not preceded by a handshake
    logic [AW-1:0] wa_q[$];
    logic [WW-1:0] wd_q[$];
    int            done_cnt = 0;
    int            we_bad   = 0;
    logic          hs_prev  = 1'b0;

    always @(negedge clock) begin
        if (iMem_WEPin === 1'b1) begin
            wa_q.push_back(iMem_WEAddress);
            wd_q.push_back(idataWrite);
            if (!hs_prev) we_bad++;
        end
        if (done === 1'b1) done_cnt++;
        hs_prev = in_valid & in_ready;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        tick();
        start     = 1'b0;
        base_addr = $urandom_range(255);
    endtask

    // Offers ch[0..n-1]; gap_pct is the chance of an idle cycle. Returns chunks accepted.
    task automatic drive_chunks(input int n, input int gap_pct, input bit inject, output int acc);
        int cyc = 0;
        bit hs;
        acc = 0;
        while (acc < n && cyc < 400) begin
            if (inject && acc >= 2 && acc <= 3) begin
                start     = 1'b1;
                base_addr = 8'h80;
            end else begin
                start = 1'b0;
            end
            if (int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                in_last  = 1'($urandom_range(1));
            end else begin
                in_valid = 1'b1;
                in_data  = ch[acc];
                in_last  = lst[acc];
            end
            hs = in_valid && in_ready;
            tick();
            if (hs) acc++;
            cyc++;
            if (!busy) break;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_session(input string name, input logic [AW-1:0] b, input int n,
                               input int gap_pct, input bit inject);
        logic [AW-1:0] ea[$];
        logic [WW-1:0] ed[$];
        logic [WW-1:0] w;
        logic [AW-1:0] a;
        int k, exp_acc, acc, cyc;
        bit err;
        // Reference: fill 5 slots per word from slot 0 upward, write on full word or last,
        // stop after the last chunk or after a write at the top address.
        a = b; w = '0; k = 0; err = 0; exp_acc = 0;
        for (int i = 0; i < n; i++) begin
            w[k*CW +: CW] = ch[i];
            k++;
            exp_acc++;
            if (k == CH || lst[i]) begin
                ea.push_back(a);
                ed.push_back(w);
                w = '0;
                k = 0;
                if (lst[i]) break;
                if (a == 8'hFF) begin
                    err = 1;
                    break;
                end
                a = a + 1'b1;
            end
        end

        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        we_bad   = 0;
        do_start(b);
        drive_chunks(n, gap_pct, inject, acc);
        cyc = 0;
        while (busy && cyc < 50) begin
            tick();
            cyc++;
        end
        chk({name, "_end_timeout"}, 256'(busy), 256'(0));
        tick();
        tick();
        chk({name, "_accepted"}, 256'(acc), 256'(exp_acc));
        chk({name, "_nwrites"}, 256'(wa_q.size()), 256'(ea.size()));
        for (int i = 0; i < ea.size() && i < wa_q.size(); i++) begin
            chk($sformatf("%s_addr%0d", name, i), 256'(wa_q[i]), 256'(ea[i]));
            chk($sformatf("%s_data%0d", name, i), 256'(wd_q[i]), 256'(ed[i]));
        end
        chk({name, "_word_count"}, 256'(word_count), 256'(ea.size()));
        chk({name, "_error"}, 256'(error), 256'(err));
        chk({name, "_done_pulses"}, 256'(done_cnt), 256'(1));
        chk({name, "_we_latency"}, 256'(we_bad), 256'(0));
        chk({name, "_in_ready_idle"}, 256'(in_ready), 256'(0));
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_in_ready"}, 256'(in_ready), 256'(0));
        chk({name, "_we"}, 256'(iMem_WEPin), 256'(0));
        chk({name, "_busy"}, 256'(busy), 256'(0));
        chk({name, "_done"}, 256'(done), 256'(0));
        chk({name, "_error"}, 256'(error), 256'(0));
        chk({name, "_we_addr"}, 256'(iMem_WEAddress), 256'(0));
        chk({name, "_wdata"}, 256'(idataWrite), 256'(0));
        chk({name, "_word_count"}, 256'(word_count), 256'(0));
    endtask

    task automatic seq_program(input int n, input bit last_on_final);
        for (int i = 0; i < 16; i++) begin
            ch[i]  = CW'(i + 1);
            lst[i] = last_on_final && (i == n - 1);
        end
    endtask

    initial begin
        int acc;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_all_zero("reset");

        seq_program(10, 1);
        run_session("normal", 8'h10, 10, 0, 0);

        seq_program(7, 1);
        run_session("partial", 8'h00, 7, 0, 0);

        seq_program(5, 1);
        run_session("gaps", 8'h40, 5, 60, 0);

        seq_program(10, 1);
        run_session("overflow", 8'hFF, 10, 0, 0);

        // Reset in the middle of a word: the partial word must never reach the SRAM
        wa_q.delete();
        wd_q.delete();
        seq_program(3, 0);
        do_start(8'h30);
        drive_chunks(3, 0, 0, acc);
        chk("midreset_accepted", 256'(acc), 256'(3));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("midreset");
        for (int i = 0; i < 8; i++) tick();
        chk("midreset_no_we", 256'(wa_q.size()), 256'(0));
        check_all_zero("midreset_later");

        seq_program(5, 1);
        run_session("after_reset", 8'h20, 5, 0, 0);

        seq_program(12, 1);
        run_session("start_busy", 8'h05, 12, 20, 1);

        for (int t = 0; t < 20; t++) begin
            int n;
            logic [AW-1:0] b;
            n = $urandom_range(14, 1);
            b = ($urandom_range(3) == 0) ? AW'($urandom_range(255, 252)) : AW'($urandom_range(255));
            for (int i = 0; i < 16; i++) begin
                ch[i]  = {$urandom, $urandom};
                lst[i] = (i == n - 1);
            end
            run_session($sformatf("rand%0d", t), b, n, $urandom_range(50), 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
